spec_free_list: RTL and testbench
=================================

# spec_free_list

Speculative physical-register free list for the rename stage. Accepts up to 4 released physical tags per cycle from the architectural map table's release ports and supplies up to 4 free tags per cycle to rename. Keeps a commit pointer so that, on a branch-mispredict or exception recovery, every tag allocated to squashed instructions returns to the list in one cycle.

## Interface

**Parameters** (one per line: name, default, meaning)
- `SIZE_PHYSICAL_TABLE`, 96, total physical registers.
- `SIZE_RMT`, 32, logical registers, which equals the tags held by the committed map.
- `SIZE_PHYSICAL_LOG`, 7, tag width.
- `SIZE_FREE_LIST`, 64, queue depth (`SIZE_PHYSICAL_TABLE - SIZE_RMT`).
- `SIZE_FREE_LIST_LOG`, 6, pointer width.

**Ports** (one per line: name, direction, width, meaning)
- `clk`, in, 1, clock. This block has one clock.
- `reset`, in, 1, reset. Reset is asynchronous and active-high.
- `releasedValid0_i`..`releasedValid3_i`, in, 1 each, a committing instruction frees its old mapping.
- `releasedPhyMap0_i`..`releasedPhyMap3_i`, in, `SIZE_PHYSICAL_LOG` each, tag being freed.
- `reqFree0_i`..`reqFree3_i`, in, 1 each, rename lane k needs a destination tag this cycle.
- `recoverFlag_i`, in, 1, recovery in progress, from the active list.
- `freePhyReg0_o`..`freePhyReg3_o`, out, `SIZE_PHYSICAL_LOG` each, tag granted to lane k.
- `freeListEmpty_o`, out, 1, fewer than 4 entries available, so rename must stall.
- `freeCount_o`, out, `SIZE_FREE_LIST_LOG+1`, current free-entry count.
- `overflowErr_o`, out, 1, sticky error flag.

## Operation

**Storage**
- Circular array of `SIZE_FREE_LIST` tags.
- Registered pointers: `headPtr` (speculative read), `commitPtr` (committed read) and `tailPtr` (write), plus a registered `freeCnt`.

**Reset**
- entry[i] = `SIZE_RMT + i`.
- `headPtr` = `commitPtr` = `tailPtr` = 0.
- `freeCnt` = `SIZE_FREE_LIST`, `overflowErr_o` = 0.

**Push**
- Valid release lanes are compacted in lane order 0..3.
- The j-th valid lane is written at `tailPtr + j`.
- `tailPtr` advances by `nPush` = popcount of the `releasedValid` lanes.

**Commit tracking**
- Every valid release corresponds to one committed allocation.
- `commitPtr` advances by `nPush`.

**Pop**
- Allowed only when `freeListEmpty_o` = 0 and `recoverFlag_i` = 0.
- Lane k gets `freePhyReg_k` = entry[`headPtr` + number of requesting lanes below k].
- `headPtr` advances by `nPop` = popcount of `reqFree`.
- When pop is blocked, `nPop` = 0. Outputs still show entry[`headPtr`+k], but requesting lanes must be ignored by rename.

**Count**
- `freeCnt_next` = `freeCnt` + `nPush` − `nPop`.
- `freeListEmpty_o` = (`freeCnt` < 4), decoded from the registered count.

**Recovery** (each cycle `recoverFlag_i` = 1)
- `headPtr_next` = `commitPtr_next`, where `commitPtr_next` includes this cycle's pushes.
- `freeCnt_next` = distance from `commitPtr_next` to `tailPtr_next` modulo depth. If `tailPtr_next` == `commitPtr_next`, the count is `SIZE_FREE_LIST` when all tags are free, tracked by a full bit.
- Pops are suppressed for every cycle the flag is high; multi-cycle recovery is legal.

**Arithmetic**
- All pointer adds wrap modulo `SIZE_FREE_LIST`.
- Tags are stored and returned unmodified.

**Errors**
- `freeCnt` + `nPush` > `SIZE_FREE_LIST` sets `overflowErr_o`, which holds until reset. The overflowing pushes are dropped.
- Popping more than `freeCnt` cannot occur, because pops are gated by `freeListEmpty_o`.

## Timing

- `freePhyReg*_o` are combinational from storage and `headPtr`, so a grant is available in the same cycle as the request.
- Pushed tags become poppable the cycle after the write edge. There is no same-cycle bypass.
- `freeListEmpty_o` and `freeCount_o` reflect the state after the previous edge.
- Push and pop in the same cycle are supported, including when the list is at exactly 4 entries.
- A reset asserted mid-operation returns all state to its reset values immediately (asynchronous), regardless of `recoverFlag_i` or pending requests.

## Test plan

1. **Reset:** assert `reset`, then release it.
   - `freeCount_o` = 64, `freeListEmpty_o` = 0.
   - With no requests, `freePhyReg0..3_o` = 32, 33, 34, 35.
2. **Sparse request:** `reqFree` = 4'b1010 from the reset state.
   - `freePhyReg1_o` = 32, `freePhyReg3_o` = 33.
   - Next cycle `freeCount_o` = 62 and `freePhyReg0_o` = 34.
3. **Drain to empty:** 15 cycles of 4 requests, leaving count 4, then release {lane0 = 5, lane2 = 9} while requesting 4.
   - Count goes 4 → 2 and `freeListEmpty_o` rises.
   - After two further all-request cycles (blocked), a push of 2 makes count = 4, the flag falls, and the next grants are 5, 9, …
4. **Tail/head wrap-around:** fill and drain across entry 63→0.
   - Tags pop in FIFO order with no loss or duplication.
   - `freeCount_o` is correct at every wrap.
5. **Recovery:**
   - Allocate 12 tags (32–43), then release 3 tags (commit 3).
   - Assert `recoverFlag_i` for 2 cycles.
   - Required: `headPtr` restores to entry 3, `freeCount_o` = 64, the next grant is 35, and no pops occur while the flag is high.
6. **Overflow:** from full (64), push 1.
   - `overflowErr_o` = 1 and stays 1 until reset.
   - Count stays 64.

Source files
------------

// File: rtl/spec_free_list.sv
// Speculative physical-register free list: 4-wide release (push) and 4-wide
// allocate (pop) circular queue with a commit pointer for one-cycle recovery.
module spec_free_list #(
    parameter int SIZE_PHYSICAL_TABLE = 96,
    parameter int SIZE_RMT            = 32,
    parameter int SIZE_PHYSICAL_LOG   = 7,
    parameter int SIZE_FREE_LIST      = SIZE_PHYSICAL_TABLE - SIZE_RMT,
    parameter int SIZE_FREE_LIST_LOG  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          releasedValid0_i,
    input  logic                          releasedValid1_i,
    input  logic                          releasedValid2_i,
    input  logic                          releasedValid3_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap0_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap2_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap3_i,
    input  logic                          reqFree0_i,
    input  logic                          reqFree1_i,
    input  logic                          reqFree2_i,
    input  logic                          reqFree3_i,
    input  logic                          recoverFlag_i,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg0_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg1_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg2_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg3_o,
    output logic                          freeListEmpty_o,
    output logic [SIZE_FREE_LIST_LOG:0]   freeCount_o,
    output logic                          overflowErr_o
);

    localparam int PW = SIZE_PHYSICAL_LOG;
    localparam int LW = SIZE_FREE_LIST_LOG;
    localparam int CW = SIZE_FREE_LIST_LOG + 1;

    logic [PW-1:0] r_entry [SIZE_FREE_LIST];
    logic [LW-1:0] r_head;
    logic [LW-1:0] r_commit;
    logic [LW-1:0] r_tail;
    logic [CW-1:0] r_free_cnt;
    logic          r_commit_full;
    logic          r_overflow;

    logic [3:0]    w_rel_valid;
    logic [3:0]    w_req;
    logic [PW-1:0] w_rel_tag   [4];
    logic [2:0]    w_rel_rank  [4];
    logic [2:0]    w_req_rank  [4];
    logic [3:0]    w_wr_en;
    logic [LW-1:0] w_wr_addr   [4];
    logic [LW-1:0] w_rd_addr   [4];
    logic [PW-1:0] w_grant     [4];
    logic [2:0]    w_n_push;
    logic [2:0]    w_n_req;
    logic [2:0]    w_n_push_acc;
    logic [2:0]    w_n_pop;
    logic [CW-1:0] w_push_sum;
    logic [CW-1:0] w_room;
    logic [CW-1:0] w_commit_dist;
    logic [CW-1:0] w_free_next;
    logic [LW-1:0] w_tail_next;
    logic [LW-1:0] w_commit_next;
    logic [LW-1:0] w_head_next;
    logic [LW-1:0] w_dist_ptr;
    logic          w_overflow;
    logic          w_pop_en;
    logic          w_empty;

    assign w_rel_valid  = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
    assign w_req        = {reqFree3_i, reqFree2_i, reqFree1_i, reqFree0_i};
    assign w_rel_tag[0] = releasedPhyMap0_i;
    assign w_rel_tag[1] = releasedPhyMap1_i;
    assign w_rel_tag[2] = releasedPhyMap2_i;
    assign w_rel_tag[3] = releasedPhyMap3_i;

    // Rank of each lane among the active lanes below it: compaction offset.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_rel_rank[k] = '0;
            w_req_rank[k] = '0;
            for (int j = 0; j < k; j++) begin
                w_rel_rank[k] = w_rel_rank[k] + 3'(w_rel_valid[j]);
                w_req_rank[k] = w_req_rank[k] + 3'(w_req[j]);
            end
        end
    end

    assign w_n_push = w_rel_rank[3] + 3'(w_rel_valid[3]);
    assign w_n_req  = w_req_rank[3] + 3'(w_req[3]);

    assign w_empty  = (r_free_cnt < CW'(4));
    assign w_pop_en = !w_empty && !recoverFlag_i;
    assign w_n_pop  = w_pop_en ? w_n_req : 3'd0;

    // Releases that would exceed the depth are dropped (highest lanes first).
    assign w_push_sum   = r_free_cnt + CW'(w_n_push);
    assign w_overflow   = (w_push_sum > CW'(SIZE_FREE_LIST));
    assign w_room       = CW'(SIZE_FREE_LIST) - r_free_cnt;
    assign w_n_push_acc = w_overflow ? 3'(w_room) : w_n_push;

    assign w_tail_next   = r_tail + LW'(w_n_push_acc);
    assign w_commit_next = r_commit + LW'(w_n_push_acc);
    assign w_dist_ptr    = w_tail_next - w_commit_next;
    assign w_commit_dist = (w_dist_ptr == '0) ? (r_commit_full ? CW'(SIZE_FREE_LIST) : '0)
                                              : CW'(w_dist_ptr);

    assign w_head_next = recoverFlag_i ? w_commit_next : (r_head + LW'(w_n_pop));
    assign w_free_next = recoverFlag_i ? w_commit_dist
                                       : (r_free_cnt + CW'(w_n_push_acc) - CW'(w_n_pop));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_wr_en[gi]   = w_rel_valid[gi] && (w_rel_rank[gi] < w_n_push_acc);
            assign w_wr_addr[gi] = r_tail + LW'(w_rel_rank[gi]);
            // Blocked or idle lanes just show the entry at their own lane offset.
            assign w_rd_addr[gi] = r_head + LW'((w_pop_en && w_req[gi]) ? w_req_rank[gi] : 3'(gi));
            assign w_grant[gi]   = r_entry[w_rd_addr[gi]];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE_FREE_LIST; i++) begin
                r_entry[i] <= PW'(SIZE_RMT + i);
            end
            r_head        <= '0;
            r_commit      <= '0;
            r_tail        <= '0;
            r_free_cnt    <= CW'(SIZE_FREE_LIST);
            r_commit_full <= 1'b1;
            r_overflow    <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_en[k]) begin
                    r_entry[w_wr_addr[k]] <= w_rel_tag[k];
                end
            end
            r_head        <= w_head_next;
            r_commit      <= w_commit_next;
            r_tail        <= w_tail_next;
            r_free_cnt    <= w_free_next;
            r_commit_full <= (w_dist_ptr == '0) && (r_commit_full || (w_n_push_acc != 3'd0));
            r_overflow    <= r_overflow || w_overflow;
        end
    end

    assign freePhyReg0_o   = w_grant[0];
    assign freePhyReg1_o   = w_grant[1];
    assign freePhyReg2_o   = w_grant[2];
    assign freePhyReg3_o   = w_grant[3];
    assign freeListEmpty_o = w_empty;
    assign freeCount_o     = r_free_cnt;
    assign overflowErr_o   = r_overflow;

endmodule

// File: tb/tb_spec_free_list.sv
// Scoreboard bench for spec_free_list: stimulus queues expected grant tags,
// a negedge monitor pops and compares them on every granted lane.
module tb_spec_free_list;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_v = '0;
    logic [3:0] rel_v = '0;
    logic [6:0] rel_t [4] = '{7'd0, 7'd0, 7'd0, 7'd0};
    logic       recover = 1'b0;
    logic [6:0] grant0, grant1, grant2, grant3;
    logic       empty;
    logic [6:0] cnt;
    logic       err;

    int         n_vec = 0;
    int         n_miss = 0;
    bit         pop_en_tb = 1'b0;
    logic [6:0] exp_q [$];

    localparam logic [3:0] REQ_TAB [5] = '{4'b1111, 4'b0110, 4'b1101, 4'b1111, 4'b1000};
    localparam logic [3:0] REL_TAB [5] = '{4'b1111, 4'b0101, 4'b1011, 4'b1110, 4'b0011};

    always #5 clk = ~clk;

    spec_free_list dut (
        .clk               (clk),
        .reset             (reset),
        .releasedValid0_i  (rel_v[0]),
        .releasedValid1_i  (rel_v[1]),
        .releasedValid2_i  (rel_v[2]),
        .releasedValid3_i  (rel_v[3]),
        .releasedPhyMap0_i (rel_t[0]),
        .releasedPhyMap1_i (rel_t[1]),
        .releasedPhyMap2_i (rel_t[2]),
        .releasedPhyMap3_i (rel_t[3]),
        .reqFree0_i        (req_v[0]),
        .reqFree1_i        (req_v[1]),
        .reqFree2_i        (req_v[2]),
        .reqFree3_i        (req_v[3]),
        .recoverFlag_i     (recover),
        .freePhyReg0_o     (grant0),
        .freePhyReg1_o     (grant1),
        .freePhyReg2_o     (grant2),
        .freePhyReg3_o     (grant3),
        .freeListEmpty_o   (empty),
        .freeCount_o       (cnt),
        .overflowErr_o     (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] rq, input logic [3:0] rv,
                          input logic [6:0] t0, input logic [6:0] t1,
                          input logic [6:0] t2, input logic [6:0] t3,
                          input logic rc, input bit pe);
        req_v     = rq;
        rel_v     = rv;
        rel_t[0]  = t0;
        rel_t[1]  = t1;
        rel_t[2]  = t2;
        rel_t[3]  = t3;
        recover   = rc;
        pop_en_tb = pe;
    endtask

    task automatic idle();
        set_in(4'b0000, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic expect4(input int base);
        for (int i = 0; i < 4; i++) exp_q.push_back(7'(base + i));
    endtask

    always @(negedge clk) begin : monitor
        logic [6:0] g [4];
        if (!reset && pop_en_tb) begin
            g[0] = grant0;
            g[1] = grant1;
            g[2] = grant2;
            g[3] = grant3;
            for (int k = 0; k < 4; k++) begin
                if (req_v[k]) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL grant lane%0d: got %0d, expected no grant", k, g[k]);
                    end else begin
                        chk($sformatf("grant lane%0d", k), 32'(g[k]), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        logic [6:0] model [$];
        logic [6:0] infl [$];

        // Reset state
        do_reset();
        chk("reset count", 32'(cnt), 64);
        chk("reset empty", 32'(empty), 0);
        chk("reset err", 32'(err), 0);
        set_in(4'b0000, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b1);
        #1;
        chk("reset grant0", 32'(grant0), 32);
        chk("reset grant1", 32'(grant1), 33);
        chk("reset grant2", 32'(grant2), 34);
        chk("reset grant3", 32'(grant3), 35);

        // Sparse request 1010
        set_in(4'b1010, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b1);
        exp_q.push_back(7'd32);
        exp_q.push_back(7'd33);
        tick();
        chk("sparse count", 32'(cnt), 62);
        idle();
        #1;
        chk("sparse next grant0", 32'(grant0), 34);

        // Drain to empty
        do_reset();
        for (int c = 0; c < 15; c++) begin
            set_in(4'b1111, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b1);
            expect4(32 + 4 * c);
            tick();
        end
        chk("drain count", 32'(cnt), 4);
        chk("drain empty", 32'(empty), 0);
        set_in(4'b1111, 4'b0101, 7'd5, 7'd0, 7'd9, 7'd0, 1'b0, 1'b1);
        expect4(92);
        tick();
        chk("push+pop at 4 count", 32'(cnt), 2);
        chk("push+pop at 4 empty", 32'(empty), 1);
        for (int c = 0; c < 2; c++) begin
            set_in(4'b1111, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);
            tick();
            chk("blocked count", 32'(cnt), 2);
            chk("blocked empty", 32'(empty), 1);
        end
        set_in(4'b0000, 4'b0011, 7'd11, 7'd13, 7'd0, 7'd0, 1'b0, 1'b0);
        tick();
        chk("refill count", 32'(cnt), 4);
        chk("refill empty", 32'(empty), 0);
        set_in(4'b1111, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b1);
        exp_q.push_back(7'd5);
        exp_q.push_back(7'd9);
        exp_q.push_back(7'd11);
        exp_q.push_back(7'd13);
        tick();
        chk("after refill count", 32'(cnt), 0);

        // Wrap-around: tags recirculate through a FIFO model
        do_reset();
        model.delete();
        infl.delete();
        for (int i = 0; i < 64; i++) model.push_back(7'(32 + i));
        for (int c = 0; c < 75; c++) begin
            logic [3:0] rq;
            logic [3:0] rv;
            logic [6:0] t [4];
            bit         pe;
            chk("wrap count", 32'(cnt), 32'(model.size()));
            chk("wrap empty", 32'(empty), 32'(model.size() < 4));
            rq = (c < 15) ? 4'b1111 : REQ_TAB[c % 5];
            rv = (c < 15) ? 4'b0000 : REL_TAB[c % 5];
            if ($countones(rv) > infl.size()) rv = 4'b0000;
            for (int k = 0; k < 4; k++) t[k] = rv[k] ? infl.pop_front() : 7'd0;
            pe = (model.size() >= 4);
            if (pe) begin
                for (int k = 0; k < 4; k++) begin
                    if (rq[k]) begin
                        exp_q.push_back(model[0]);
                        infl.push_back(model.pop_front());
                    end
                end
            end
            for (int k = 0; k < 4; k++) if (rv[k]) model.push_back(t[k]);
            set_in(rq, rv, t[0], t[1], t[2], t[3], 1'b0, pe);
            tick();
        end
        idle();

        // Recovery
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(4'b1111, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b1);
            expect4(32 + 4 * c);
            tick();
        end
        set_in(4'b0000, 4'b0111, 7'd0, 7'd1, 7'd2, 7'd0, 1'b0, 1'b0);
        tick();
        chk("pre-recover count", 32'(cnt), 55);
        for (int c = 0; c < 2; c++) begin
            set_in(4'b1111, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b1, 1'b0);
            tick();
            chk("recover count", 32'(cnt), 64);
        end
        set_in(4'b1111, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b1);
        expect4(35);
        tick();
        chk("post-recover count", 32'(cnt), 60);

        // Overflow from full
        do_reset();
        set_in(4'b0000, 4'b0001, 7'd7, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);
        tick();
        chk("overflow err", 32'(err), 1);
        chk("overflow count", 32'(cnt), 64);
        idle();
        tick();
        chk("overflow sticky", 32'(err), 1);
        set_in(4'b1111, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b1);
        expect4(32);
        tick();
        chk("overflow pop count", 32'(cnt), 60);
        chk("overflow still set", 32'(err), 1);

        // Asynchronous reset mid-cycle
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("async reset count", 32'(cnt), 64);
        chk("async reset err", 32'(err), 0);
        chk("async reset grant0", 32'(grant0), 32);
        tick();
        reset = 1'b0;
        tick();

        chk("scoreboard drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
